wb_watchdog: RTL and testbench



---
 rtl/wb_watchdog_if.sv | 21 ++
 rtl/wb_watchdog.sv | 123 ++++++++++++
 tb/tb_wb_watchdog.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_watchdog_if.sv
// Wishbone slave bus bundle for wb_watchdog; signal names follow the original port list.
interface wb_watchdog_if;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_watchdog.sv
// Wishbone watchdog timer and reset-request source.
// Optional pre-timeout warning interrupt is built when WDT_WARN_IRQ_EN is defined.
module wb_watchdog #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned RST_PULSE_LEN = 16,
  parameter logic [31:0] KICK_KEY      = 32'h0000_5A5A
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_watchdog_if.slave wb,
  output logic         rst_req_o,
  output logic         irq_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIRE, HOLD} state_t;
  localparam int unsigned PW = $clog2(RST_PULSE_LEN + 1);

  state_t           state;
  logic             en, lock, ack, irq;
  logic [CNT_W-1:0] load, count;
  logic [PW-1:0]    pulse;
  logic [31:0]      dat_r, rd_val;
  logic             access, wr, wr_ctrl, wr_load, wr_kick;
  logic             swrst, kick_ok, kick_bad, en_set, dis, live;
  logic             unused;

  assign access   = wb.wb_cyc_i & wb.wb_stb_i & ~ack;
  assign wr       = access & wb.wb_we_i;
  assign wr_ctrl  = wr & (wb.wb_adr_i[3:2] == 2'd0);
  assign wr_load  = wr & (wb.wb_adr_i[3:2] == 2'd1);
  assign wr_kick  = wr & (wb.wb_adr_i[3:2] == 2'd2);
  assign swrst    = wr_ctrl & wb.wb_dat_i[8];
  assign kick_ok  = wr_kick & (wb.wb_dat_i == KICK_KEY);
  assign kick_bad = wr_kick & (wb.wb_dat_i != KICK_KEY);
  assign en_set   = wr_ctrl & ~lock & wb.wb_dat_i[0];
  assign dis      = wr_ctrl & ~lock & ~wb.wb_dat_i[0];
  assign live     = (state == IDLE) || (state == RUN);
  assign unused   = ^{wb.wb_sel_i, wb.wb_adr_i[1:0]};

  assign wb.wb_ack_o = ack;
  assign wb.wb_dat_o = dat_r;
  assign irq_o       = irq;

  always_comb begin
    rd_val = '0;
    unique case (wb.wb_adr_i[3:2])
      2'd0: begin
        rd_val[0]  = en;
        rd_val[1]  = lock;
        rd_val[16] = (state == FIRE) || (state == HOLD);
        rd_val[17] = irq;
      end
      2'd1:    rd_val[CNT_W-1:0] = load;
      2'd3:    rd_val[CNT_W-1:0] = count;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      en        <= 1'b0;
      lock      <= 1'b0;
      load      <= '0;
      count     <= '0;
      pulse     <= '0;
      ack       <= 1'b0;
      dat_r     <= '0;
      rst_req_o <= 1'b0;
    end else begin
      ack       <= access;
      dat_r     <= access ? rd_val : '0;
      // Request trails the state by one edge, so it is high exactly while FIRE was held.
      rst_req_o <= (state == FIRE);

      if (wr_ctrl && live && !lock && !swrst) begin
        en   <= wb.wb_dat_i[0];
        lock <= wb.wb_dat_i[1];
      end
      if (wr_load && live && !lock) load <= wb.wb_dat_i[CNT_W-1:0];

      unique case (state)
        IDLE: begin
          if (swrst) begin
            state <= FIRE;
            pulse <= '0;
          end else if (en_set) begin
            state <= RUN;
            count <= load;
          end
        end
        RUN: begin
          if (swrst || kick_bad) begin
            state <= FIRE;
            pulse <= '0;
          end else if (kick_ok) begin
            count <= load;
          end else if (dis) begin
            state <= IDLE;
          end else if (count == '0) begin
            state <= FIRE;
            pulse <= '0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        FIRE: begin
          if (pulse == PW'(RST_PULSE_LEN - 1)) state <= HOLD;
          else pulse <= pulse + PW'(1);
        end
        HOLD: state <= HOLD;
      endcase
    end
  end

`ifdef WDT_WARN_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) irq <= 1'b0;
    else       irq <= (state == RUN) && (count <= (load >> 1));
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_wb_watchdog.sv
// Self-checking bench for wb_watchdog: directed scenarios plus random bus traffic vs a behavioural model.
module tb_wb_watchdog;
  localparam int unsigned CNT_W = 32;
  localparam int          PLEN  = 16;
  localparam logic [31:0] KEY   = 32'h0000_5A5A;
  localparam longint      MASK  = (64'd1 << CNT_W) - 1;
`ifdef WDT_WARN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_req, irq;

  wb_watchdog_if wb();

  wb_watchdog #(.CNT_W(CNT_W), .RST_PULSE_LEN(PLEN), .KICK_KEY(KEY)) dut (
    .clk_i(clk), .rst_i(rst), .wb(wb), .rst_req_o(rst_req), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: running flag, counter, and age since the watchdog fired
  // (FIRE while age < PLEN, HOLD afterwards, -1 when not fired).
  bit          m_run, m_en, m_lock;
  longint      m_count, m_load;
  int          fire_age = -1;
  bit          e_ack, e_rq, e_irq;
  logic [31:0] e_dat;
  bit          acc, fired, wr, old_lock, go_fire;
  int          a;
  logic [31:0] d, rv;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_en = 0; m_lock = 0; m_count = 0; m_load = 0; fire_age = -1;
      e_ack = 0; e_rq = 0; e_irq = 0; e_dat = '0;
    end else begin
      fired = (fire_age >= 0);
      acc   = wb.wb_cyc_i && wb.wb_stb_i && !e_ack;
      wr    = acc && wb.wb_we_i;
      a     = int'(wb.wb_adr_i[3:2]);
      d     = wb.wb_dat_i;
      rv    = '0;
      if (a == 0)      rv = {14'd0, e_irq, fired, 14'd0, m_lock, m_en};
      else if (a == 1) rv = 32'(m_load);
      else if (a == 3) rv = 32'(m_count);
      e_rq  = fired && (fire_age < PLEN);
      e_irq = IRQ_ON && m_run && (m_count <= m_load / 2);
      e_ack = acc;
      e_dat = acc ? rv : '0;
      if (fired) begin
        if (fire_age < PLEN) fire_age++;
      end else begin
        old_lock = m_lock;
        go_fire  = 0;
        if (wr && a == 0 && d[8]) go_fire = 1;
        else if (wr && a == 2 && m_run) begin
          if (d == KEY) m_count = m_load;
          else go_fire = 1;
        end
        else if (wr && a == 0 && !old_lock && m_run && !d[0]) m_run = 0;
        else if (wr && a == 0 && !old_lock && !m_run && d[0]) begin
          m_run = 1;
          m_count = m_load;
        end
        else if (m_run && m_count == 0) go_fire = 1;
        else if (m_run) m_count--;
        if (go_fire) begin
          m_run = 0;
          fire_age = 0;
        end
        if (wr && a == 0 && !d[8] && !old_lock) begin
          m_en = d[0];
          m_lock = d[1];
        end
        if (wr && a == 1 && !old_lock) m_load = longint'(d) & MASK;
      end
    end
  end

  always @(negedge clk) begin
    check("ack", {31'd0, wb.wb_ack_o}, {31'd0, e_ack});
    check("rst_req", {31'd0, rst_req}, {31'd0, e_rq});
    check("irq", {31'd0, irq}, {31'd0, e_irq});
    if (e_ack) check("dat", wb.wb_dat_o, e_dat);
  end

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic bus(input bit we, input logic [1:0] r, input logic [31:0] dw, output logic [31:0] q);
    int n;
    @(negedge clk);
    wb.wb_adr_i = {r, 2'b00}; wb.wb_dat_i = dw; wb.wb_we_i = we;
    wb.wb_sel_i = 4'hF; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.wb_ack_o && n < 8);
    q = wb.wb_dat_o;
    check("ack_latency", n, 1);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic wait_rq(input logic level, input int max, output int n);
    n = 0;
    while (rst_req !== level && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] q;
  int n;

  initial begin
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
    wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state: all registers read 0
    for (int r = 0; r < 4; r++) begin
      bus(0, 2'(r), '0, q);
      check("reset_read", q, 32'h0);
    end
    check("reset_rst_req", {31'd0, rst_req}, 32'h0);

    // Timeout with no kicks
    bus(1, 2'd1, 32'd100, q);
    bus(1, 2'd0, 32'h1, q);
    wait_rq(1'b1, 300, n);
    check("t2_fire_latency", n, 102);
    wait_rq(1'b0, 100, n);
    check("t2_pulse_len", n, 16);
    bus(0, 2'd0, '0, q);
    check("t2_fired_ctrl", q, 32'h0001_0001);
    do_reset();
    bus(0, 2'd3, '0, q);
    check("t2_count_after_rst", q, 32'h0);
    bus(0, 2'd0, '0, q);
    check("t2_ctrl_after_rst", q, 32'h0);

    // Periodic valid kicks, then a bad kick
    bus(1, 2'd1, 32'd100, q);
    bus(1, 2'd0, 32'h1, q);
    for (int k = 0; k < 20; k++) begin
      repeat (45) @(negedge clk);
      bus(1, 2'd2, KEY, q);
    end
    bus(1, 2'd2, 32'h1234, q);
    check("t3_rq_at_ack", {31'd0, rst_req}, 32'h0);
    @(negedge clk);
    check("t3_rq_after_ack", {31'd0, rst_req}, 32'h1);
    wait_rq(1'b0, 100, n);
    do_reset();

    // Kick landing exactly on COUNT==0, then lock
    bus(1, 2'd1, 32'd20, q);
    bus(1, 2'd0, 32'h1, q);
    repeat (19) @(negedge clk);
    bus(1, 2'd2, KEY, q);
    bus(0, 2'd3, '0, q);
    check("t4_count_reloaded", q, 32'd19);
    bus(1, 2'd0, 32'h3, q);
    bus(1, 2'd0, 32'h0, q);
    bus(1, 2'd1, 32'd5, q);
    bus(0, 2'd1, '0, q);
    check("t4_load_locked", q, 32'd20);
    bus(0, 2'd0, '0, q);
    check("t4_ctrl_locked", q, 32'h3);
    wait_rq(1'b1, 60, n);
    check("t4_timeout", {31'd0, rst_req}, 32'h1);
    wait_rq(1'b0, 100, n);
    do_reset();

    // Software reset, interrupted by rst_i in the 5th pulse cycle
    bus(1, 2'd1, 32'd1000, q);
    bus(1, 2'd0, 32'h1, q);
    repeat (10) @(negedge clk);
    bus(1, 2'd0, 32'h101, q);
    repeat (5) @(negedge clk);
    check("t5_rq_mid_pulse", {31'd0, rst_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rq_dropped", {31'd0, rst_req}, 32'h0);
    rst = 1'b0;
    bus(0, 2'd0, '0, q);
    check("t5_ctrl_idle", q, 32'h0);

    // Warning interrupt
    bus(1, 2'd1, 32'd40, q);
    bus(1, 2'd0, 32'h1, q);
    repeat (20) @(negedge clk);
    check("t6_irq_before", {31'd0, irq}, 32'h0);
    @(negedge clk);
    check("t6_irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
    repeat (3) @(negedge clk);
    bus(1, 2'd2, KEY, q);
    check("t6_irq_at_kick", {31'd0, irq}, {31'd0, IRQ_ON});
    @(negedge clk);
    check("t6_irq_cleared", {31'd0, irq}, 32'h0);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [31:0] cv;
      op = int'($urandom_range(0, 9));
      if (fire_age >= PLEN || $urandom_range(0, 39) == 0) do_reset();
      else if (op <= 1) bus(1, 2'd1, $urandom_range(0, 60), q);
      else if (op <= 3) begin
        cv = '0;
        cv[0] = 1'($urandom_range(0, 3) != 0);
        cv[1] = 1'($urandom_range(0, 9) == 0);
        cv[8] = 1'($urandom_range(0, 14) == 0);
        cv[31:9] = 23'($urandom);
        bus(1, 2'd0, cv, q);
      end
      else if (op <= 6) bus(1, 2'd2, ($urandom_range(0, 7) != 0) ? KEY : $urandom, q);
      else bus(0, 2'($urandom_range(0, 3)), '0, q);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
